// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler: arbitrates burst write/read requests between the camera
// write FIFO and the LCD read FIFO in front of the SDRAM interface. Each direction
// keeps its own frame address. The address advances by one burst length per
// completed burst and wraps to its base at the frame end. Frame-sync pulses
// restart the address. A pulse that arrives mid-burst is held until that burst
// completes.
// Optional build macro: SDRAM_PINGPONG_EN. When it is defined, address bit 23
// selects one of two frame-buffer halves, and reads always use the half opposite
// to the one being written.
module sdram_req_scheduler #(
  parameter logic [23:0] WR_BASE   = 24'd0,
  parameter logic [23:0] WR_END    = 24'd130560,
  parameter logic [23:0] RD_BASE   = 24'd0,
  parameter logic [23:0] RD_END    = 24'd130560,
  parameter logic [9:0]  WR_BURST  = 10'd512,
  parameter logic [9:0]  RD_BURST  = 10'd512,
  parameter logic [9:0]  RD_THRESH = 10'd512
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_init_done,
  input  logic [9:0]  i_wfifo_cnt,
  input  logic [9:0]  i_rfifo_cnt,
  input  logic        i_rd_en,
  input  logic        i_wr_frame_rst,
  input  logic        i_rd_frame_rst,
  input  logic        i_wr_ack,
  input  logic        i_rd_ack,
  output logic        o_wr_req,
  output logic [23:0] o_wr_addr,
  output logic [9:0]  o_wr_burst_len,
  output logic        o_rd_req,
  output logic [23:0] o_rd_addr,
  output logic [9:0]  o_rd_burst_len,
  output logic        o_wr_frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_WR_REQ = 3'd2,
    ST_WR_RUN = 3'd3,
    ST_RD_REQ = 3'd4,
    ST_RD_RUN = 3'd5
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [23:0] wr_addr_r, rd_addr_r;
  logic [9:0]  wr_len_r, rd_len_r;
  logic        wr_req_r, rd_req_r, wr_frame_done_r;
  logic        wr_ack_d_r, rd_ack_d_r;
  logic        wr_rst_pend_r, rd_rst_pend_r;
  logic        last_wr_r;  // 1: last burst served was a write
  logic [9:0]  wr_len_s, rd_len_s;
  logic        wr_elig_s, rd_elig_s;
  logic        wr_start_s, rd_start_s, wr_done_s, rd_done_s;
  logic        wr_busy_s, rd_busy_s, wr_rst_now_s, rd_rst_now_s;
  logic [23:0] wr_inc_s, rd_inc_s;
  logic        wr_wrap_evt_s, rd_half_load_s;

  // Burst length: the distance to the frame end, capped at the nominal burst.
  function automatic logic [9:0] burst_len(input logic [23:0] addr,
                                           input logic [23:0] end_addr,
                                           input logic [9:0]  burst);
    logic [23:0] diff;
    diff = end_addr - addr;
    if (diff >= 24'd1024)
      burst_len = burst;
    else if (diff[9:0] < burst)
      burst_len = diff[9:0];
    else
      burst_len = burst;
  endfunction

  assign wr_len_s  = burst_len(wr_addr_r, WR_END, WR_BURST);
  assign rd_len_s  = burst_len(rd_addr_r, RD_END, RD_BURST);
  assign wr_elig_s = (i_wfifo_cnt >= wr_len_s);
  assign rd_elig_s = i_rd_en && (i_rfifo_cnt < RD_THRESH);
  assign wr_inc_s  = wr_addr_r + {14'd0, wr_len_r};
  assign rd_inc_s  = rd_addr_r + {14'd0, rd_len_r};
  assign wr_busy_s = (state_r == ST_WR_REQ) || (state_r == ST_WR_RUN);
  assign rd_busy_s = (state_r == ST_RD_REQ) || (state_r == ST_RD_RUN);

  // State register
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) state_r <= ST_IDLE;
    else             state_r <= state_nxt_s;
  end

  // Next-state decode, round-robin arbitration and burst start/done strobes
  always_comb begin
    state_nxt_s = state_r;
    wr_start_s  = 1'b0;
    rd_start_s  = 1'b0;
    wr_done_s   = 1'b0;
    rd_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_init_done) state_nxt_s = ST_ARB;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ARB: begin
        // A frame reset in ARB reloads the address first, so the next decision
        // and its registered address/length see the restarted frame.
        if (i_wr_frame_rst || i_rd_frame_rst) begin
          state_nxt_s = ST_ARB;
        end else if (wr_elig_s && (!rd_elig_s || !last_wr_r)) begin
          state_nxt_s = ST_WR_REQ;
          wr_start_s  = 1'b1;
        end else if (rd_elig_s) begin
          state_nxt_s = ST_RD_REQ;
          rd_start_s  = 1'b1;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_WR_REQ: begin
        if (i_wr_ack) state_nxt_s = ST_WR_RUN;
        else          state_nxt_s = ST_WR_REQ;
      end
      ST_WR_RUN: begin
        if (wr_ack_d_r && !i_wr_ack) begin
          state_nxt_s = ST_ARB;
          wr_done_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WR_RUN;
        end
      end
      ST_RD_REQ: begin
        if (i_rd_ack) state_nxt_s = ST_RD_RUN;
        else          state_nxt_s = ST_RD_REQ;
      end
      ST_RD_RUN: begin
        if (rd_ack_d_r && !i_rd_ack) begin
          state_nxt_s = ST_ARB;
          rd_done_s   = 1'b1;
        end else begin
          state_nxt_s = ST_RD_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Frame-reset routing: apply now unless this direction has a burst in flight
  always_comb begin
    wr_rst_now_s   = 1'b0;
    rd_rst_now_s   = 1'b0;
    wr_wrap_evt_s  = 1'b0;
    rd_half_load_s = 1'b0;
    if (i_wr_frame_rst && !wr_busy_s) wr_rst_now_s = 1'b1;
    else                              wr_rst_now_s = 1'b0;
    if (i_rd_frame_rst && !rd_busy_s) rd_rst_now_s = 1'b1;
    else                              rd_rst_now_s = 1'b0;
    if (wr_done_s && !(wr_rst_pend_r || i_wr_frame_rst) && (wr_inc_s == WR_END))
      wr_wrap_evt_s = 1'b1;
    else
      wr_wrap_evt_s = 1'b0;
    if (rd_rst_now_s || (rd_done_s && (rd_rst_pend_r || i_rd_frame_rst || (rd_inc_s == RD_END))))
      rd_half_load_s = 1'b1;
    else
      rd_half_load_s = 1'b0;
  end

  // Write channel: request, length, address advance/wrap and frame-done pulse
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      wr_req_r        <= 1'b0;
      wr_len_r        <= 10'd0;
      wr_addr_r       <= WR_BASE;
      wr_ack_d_r      <= 1'b0;
      wr_rst_pend_r   <= 1'b0;
      wr_frame_done_r <= 1'b0;
    end else begin
      wr_ack_d_r      <= i_wr_ack;
      wr_req_r        <= (state_nxt_s == ST_WR_REQ);
      wr_frame_done_r <= wr_wrap_evt_s;
      if (wr_start_s) wr_len_r <= wr_len_s;
      if (wr_rst_now_s) begin
        wr_addr_r     <= WR_BASE;
        wr_rst_pend_r <= 1'b0;
      end else if (wr_done_s) begin
        wr_rst_pend_r <= 1'b0;
        if (wr_rst_pend_r || i_wr_frame_rst || (wr_inc_s == WR_END))
          wr_addr_r <= WR_BASE;
        else
          wr_addr_r <= wr_inc_s;
      end else if (i_wr_frame_rst) begin
        wr_rst_pend_r <= 1'b1;
      end
    end
  end

  // Read channel: request, length and address advance/wrap
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      rd_req_r      <= 1'b0;
      rd_len_r      <= 10'd0;
      rd_addr_r     <= RD_BASE;
      rd_ack_d_r    <= 1'b0;
      rd_rst_pend_r <= 1'b0;
    end else begin
      rd_ack_d_r <= i_rd_ack;
      rd_req_r   <= (state_nxt_s == ST_RD_REQ);
      if (rd_start_s) rd_len_r <= rd_len_s;
      if (rd_rst_now_s) begin
        rd_addr_r     <= RD_BASE;
        rd_rst_pend_r <= 1'b0;
      end else if (rd_done_s) begin
        rd_rst_pend_r <= 1'b0;
        if (rd_rst_pend_r || i_rd_frame_rst || (rd_inc_s == RD_END))
          rd_addr_r <= RD_BASE;
        else
          rd_addr_r <= rd_inc_s;
      end else if (i_rd_frame_rst) begin
        rd_rst_pend_r <= 1'b1;
      end
    end
  end

  // Round-robin memory: which direction completed most recently
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n)    last_wr_r <= 1'b0;
    else if (wr_done_s) last_wr_r <= 1'b1;
    else if (rd_done_s) last_wr_r <= 1'b0;
  end

`ifdef SDRAM_PINGPONG_EN
  logic wr_half_r, rd_half_r;

  // Buffer-half selection: write flips on wrap, read takes the opposite half
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      wr_half_r <= 1'b0;
      rd_half_r <= 1'b1;
    end else begin
      if (wr_wrap_evt_s)  wr_half_r <= ~wr_half_r;
      if (rd_half_load_s) rd_half_r <= ~wr_half_r;
    end
  end

  assign o_wr_addr = {wr_half_r, wr_addr_r[22:0]};
  assign o_rd_addr = {rd_half_r, rd_addr_r[22:0]};
`else
  assign o_wr_addr = wr_addr_r;
  assign o_rd_addr = rd_addr_r;
`endif

  assign o_wr_req        = wr_req_r;
  assign o_rd_req        = rd_req_r;
  assign o_wr_burst_len  = wr_len_r;
  assign o_rd_burst_len  = rd_len_r;
  assign o_wr_frame_done = wr_frame_done_r;

endmodule
